pcie_cpl_rx: RTL and testbench
==============================

PCIE_CPL_RX -- requirements
Module: pcie_cpl_rx

Interface
REQ-001 Parameter ID_W, default 4, sets the AXI R ID width, taken from cpl_requestID_i[ID_W-1:0].
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 cpl_valid_i  input  1  completion TLP present from the RX data-link side.
REQ-005 cpl_ready_o  output  1  block accepts the TLP.
REQ-006 cpl_fmt_i  input  3  TLP fmt field.
REQ-007 cpl_type_i  input  5  TLP type field.
REQ-008 cpl_length_i  input  9  payload length in DW.
REQ-009 cpl_requestID_i  input  16  requester ID; low ID_W bits are the AXI ID.
REQ-010 cpl_data_i  input  1024  payload; DW k is bits [32k+31:32k].
REQ-011 r_valid_o, r_ready_i, r_id_o[ID_W], r_data_o[32], r_resp_o[2], r_last_o: AXI R channel source; r_valid_o and r_ready_i are 1 bit, r_last_o is 1 bit.
REQ-012 cpl_cnt_o  output  16  count of completed TLPs.
REQ-013 err_cnt_o  output  8  count of malformed TLPs.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BEAT and ERR.
REQ-015 IDLE: cpl_ready_o=1; all other states: cpl_ready_o=0.
REQ-016 Acceptance (cpl_valid_i & cpl_ready_o): capture data, length and ID into registers, then move to:
- BEAT, when the TLP is well-formed.
- ERR, otherwise.
REQ-017 Well-formed means all three of:
- fmt==3'b010.
- type==5'b01010 (CplD).
- 1<=length<=32.
REQ-018 r_valid_o SHALL rise in the cycle after acceptance, giving 1-cycle latency; it is never combinationally dependent on cpl_valid_i.
REQ-019 BEAT, r_valid_o=1:
- r_data_o = captured DW[idx], where idx is a 5-bit beat index that is 0 on entry.
- r_resp_o=2'b00.
- r_id_o = captured ID.
- r_last_o=1 only when idx==length-1.
REQ-020 BEAT with r_ready_i=1 and r_last_o=0: idx increments by one; r_valid_o stays 1 with no bubble.
REQ-021 BEAT with r_ready_i=0: all R outputs hold stable until the handshake.
REQ-022 BEAT, handshake with r_last_o=1: go to IDLE and increment cpl_cnt_o, which wraps 0xFFFF->0x0000.
REQ-023 ERR: exactly one beat with r_valid_o=1, r_data_o=0, r_resp_o=2'b10, r_last_o=1 and r_id_o = captured ID.
REQ-024 ERR handshake: go to IDLE and increment err_cnt_o, saturating at 255; cpl_cnt_o is unchanged.
REQ-025 IDLE: r_valid_o=0 and r_last_o=0.
REQ-026 A TLP presented while not in IDLE SHALL be back-pressured (not dropped) and accepted on the first IDLE cycle with cpl_valid_i=1.
REQ-027 Back-to-back TLPs: the earliest acceptance of the next TLP is the cycle after the last-beat handshake; this is a 1-cycle IDLE turnaround.
REQ-028 length=32 SHALL emit 32 beats, idx 0..31; idx SHALL NOT wrap before r_last_o.

Reset
REQ-029 When rst_n=0 at a clock edge, the next state SHALL be:
- FSM=IDLE, idx=0.
- r_valid_o=0, r_last_o=0, r_data_o=0, r_resp_o=0, r_id_o=0.
- cpl_cnt_o=0, err_cnt_o=0.
REQ-030 cpl_ready_o SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-031 Reset mid-burst SHALL abandon the burst with no further beats; the partial TLP SHALL NOT be counted.

Verification
REQ-032 CplD, length=4, DW k=0xA0+k, requestID=0x0003, r_ready_i tied 1:
- r_valid_o rises 1 cycle after acceptance.
- Four consecutive beats 0xA0..0xA3, r_id_o=3.
- r_last_o on beat 3.
- cpl_cnt_o=1.
REQ-033 Same TLP, r_ready_i toggling 1,0,0,1,...: data holds during stalls; exactly 4 beats; cpl_valid_i held high for a second TLP is not accepted until 1 cycle after the last beat.
REQ-034 Malformed TLPs: fmt=3'b000 (MRd), length=0, length=33 -> each gives one beat with r_resp_o=2'b10, r_last_o=1, r_data_o=0; err_cnt_o=3; cpl_cnt_o unchanged.
REQ-035 length=32, payload DW k=k -> 32 beats 0..31, r_last_o only on beat 31.
REQ-036 rst_n=0 at beat 2 of a length-8 TLP -> no beats after reset, counters=0, cpl_ready_o=1 after release; next TLP completes normally.
REQ-037 Preload 255 malformed TLPs then send 1 more -> err_cnt_o stays 255.

Source files
------------

// File: rtl/pcie_cpl_rx.sv
// PCIe CplD receiver: captures one completion TLP and replays its payload as AXI R beats; malformed TLPs yield one SLVERR beat.
// First beat 1 cycle after acceptance; R outputs hold while r_ready_i=0; new TLPs stall (cpl_ready_o=0) until the FSM is back in IDLE.
module pcie_cpl_rx #(
    parameter int ID_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpl_valid_i,
    output logic              cpl_ready_o,
    input  logic [2:0]        cpl_fmt_i,
    input  logic [4:0]        cpl_type_i,
    input  logic [8:0]        cpl_length_i,
    input  logic [15:0]       cpl_requestID_i,
    input  logic [1023:0]     cpl_data_i,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic [ID_W-1:0]   r_id_o,
    output logic [31:0]       r_data_o,
    output logic [1:0]        r_resp_o,
    output logic              r_last_o,
    output logic [15:0]       cpl_cnt_o,
    output logic [7:0]        err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0]      len;
        logic [ID_W-1:0] id;
    } meta_t;

    localparam logic [2:0] FMT_CPLD  = 3'b010;
    localparam logic [4:0] TYPE_CPLD = 5'b01010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    meta_t           meta_q, meta_d;
    logic [1023:0]   data_q, data_d;
    logic [15:0]     cpl_cnt_q, cpl_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            well_formed;
    logic            last_beat;
    logic            accept;

    // Requester-ID bits above the AXI ID width carry no meaning here.
    generate
        if (ID_W < 16) begin : g_rid_unused
            logic unused_rid;
            assign unused_rid = ^cpl_requestID_i[15:ID_W];
        end
    endgenerate

    assign well_formed = (cpl_fmt_i == FMT_CPLD) && (cpl_type_i == TYPE_CPLD) &&
                         (cpl_length_i >= 9'd1) && (cpl_length_i <= 9'd32);

    // len_q is 1..32 in BEAT, so idx never needs to reach 32 before last.
    assign last_beat = ({1'b0, idx_q} == (meta_q.len - 6'd1));

    // Gated by rst_n so the source never sees ready during reset.
    assign cpl_ready_o = rst_n && (state_q == IDLE);
    assign accept      = cpl_valid_i && cpl_ready_o;

    assign cpl_cnt_o = cpl_cnt_q;
    assign err_cnt_o = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        meta_d    = meta_q;
        data_d    = data_q;
        cpl_cnt_d = cpl_cnt_q;
        err_cnt_d = err_cnt_q;
        r_valid_o = 1'b0;
        r_id_o    = '0;
        r_data_o  = '0;
        r_resp_o  = RESP_OKAY;
        r_last_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d      = cpl_data_i;
                    meta_d.id   = cpl_requestID_i[ID_W-1:0];
                    meta_d.len  = cpl_length_i[5:0];
                    idx_d       = '0;
                    state_d     = well_formed ? BEAT : ERR;
                end
            end
            BEAT: begin
                r_valid_o = 1'b1;
                r_id_o    = meta_q.id;
                r_data_o  = data_q[{idx_q, 5'd0} +: 32];
                r_last_o  = last_beat;
                if (r_ready_i) begin
                    if (last_beat) begin
                        state_d   = IDLE;
                        idx_d     = '0;
                        cpl_cnt_d = cpl_cnt_q + 16'd1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ERR: begin
                r_valid_o = 1'b1;
                r_id_o    = meta_q.id;
                r_resp_o  = RESP_SLVERR;
                r_last_o  = 1'b1;
                if (r_ready_i) begin
                    state_d = IDLE;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            meta_q    <= '0;
            cpl_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            meta_q    <= meta_d;
            cpl_cnt_q <= cpl_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Payload is only observed in BEAT, which is always entered through a capture.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_pcie_cpl_rx.sv
// Directed bench for pcie_cpl_rx: drives on posedge+1, samples on negedge.
module tb_pcie_cpl_rx;

    logic          clk;
    logic          rst_n;
    logic          cpl_valid_i;
    logic          cpl_ready_o;
    logic [2:0]    cpl_fmt_i;
    logic [4:0]    cpl_type_i;
    logic [8:0]    cpl_length_i;
    logic [15:0]   cpl_requestID_i;
    logic [1023:0] cpl_data_i;
    logic          r_valid_o;
    logic          r_ready_i;
    logic [3:0]    r_id_o;
    logic [31:0]   r_data_o;
    logic [1:0]    r_resp_o;
    logic          r_last_o;
    logic [15:0]   cpl_cnt_o;
    logic [7:0]    err_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cpl  = 0;
    int exp_err  = 0;

    pcie_cpl_rx #(.ID_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpl_valid_i    (cpl_valid_i),
        .cpl_ready_o    (cpl_ready_o),
        .cpl_fmt_i      (cpl_fmt_i),
        .cpl_type_i     (cpl_type_i),
        .cpl_length_i   (cpl_length_i),
        .cpl_requestID_i(cpl_requestID_i),
        .cpl_data_i     (cpl_data_i),
        .r_valid_o      (r_valid_o),
        .r_ready_i      (r_ready_i),
        .r_id_o         (r_id_o),
        .r_data_o       (r_data_o),
        .r_resp_o       (r_resp_o),
        .r_last_o       (r_last_o),
        .cpl_cnt_o      (cpl_cnt_o),
        .err_cnt_o      (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1023:0] mk_payload(input logic [31:0] base);
        logic [1023:0] p;
        p = '0;
        for (int k = 0; k < 32; k++) p[32*k +: 32] = base + k;
        return p;
    endfunction

    task automatic drive_tlp(input logic [2:0] fmt, input logic [4:0] typ,
                             input logic [8:0] len, input logic [15:0] rid,
                             input logic [31:0] base);
        cpl_fmt_i       = fmt;
        cpl_type_i      = typ;
        cpl_length_i    = len;
        cpl_requestID_i = rid;
        cpl_data_i      = mk_payload(base);
        cpl_valid_i     = 1'b1;
    endtask

    // Presents a TLP, waits (bounded) for ready, returns at posedge+1 after acceptance.
    task automatic accept_tlp(input logic [2:0] fmt, input logic [4:0] typ,
                              input logic [8:0] len, input logic [15:0] rid,
                              input logic [31:0] base, output bit ok);
        ok = 1'b0;
        drive_tlp(fmt, typ, len, rid, base);
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (cpl_ready_o === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        cpl_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (cpl_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", cpl_ready_o); end
        n_checks++; if ({r_valid_o, r_last_o, r_resp_o, r_id_o} !== 8'h00) begin n_fail++; $display("FAIL rst_r_ctrl got=%h exp=00", {r_valid_o, r_last_o, r_resp_o, r_id_o}); end
        n_checks++; if (r_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_r_data got=%h exp=0", r_data_o); end
        n_checks++; if ({cpl_cnt_o, err_cnt_o} !== 24'h0) begin n_fail++; $display("FAIL rst_counters got=%h exp=0", {cpl_cnt_o, err_cnt_o}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cpl_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", cpl_ready_o); end
        n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", r_valid_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        r_ready_i = 1'b1;
        accept_tlp(3'b010, 5'b01010, 9'd4, 16'h0003, 32'hA0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_accept got=timeout exp=accepted"); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            n_checks++; if (r_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid b=%0d got=%b exp=1", b, r_valid_o); end
            n_checks++; if (r_data_o !== 32'hA0 + b) begin n_fail++; $display("FAIL basic_data b=%0d got=%h exp=%h", b, r_data_o, 32'hA0 + b); end
            n_checks++; if (r_id_o !== 4'd3 || r_resp_o !== 2'b00) begin n_fail++; $display("FAIL basic_id_resp b=%0d got=%h/%b exp=3/00", b, r_id_o, r_resp_o); end
            n_checks++; if (r_last_o !== (b == 3)) begin n_fail++; $display("FAIL basic_last b=%0d got=%b exp=%b", b, r_last_o, b == 3); end
            @(posedge clk); #1;
        end
        exp_cpl++;
        @(negedge clk);
        n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid got=%b exp=0", r_valid_o); end
        n_checks++; if (cpl_cnt_o !== 16'(exp_cpl)) begin n_fail++; $display("FAIL basic_cpl_cnt got=%0d exp=%0d", cpl_cnt_o, exp_cpl); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit [3:0] pat = 4'b1001;
        bit       ok;
        int       hs, stalls;
        ok = 1'b0;
        hs = 0;
        stalls = 0;
        r_ready_i = 1'b1;
        drive_tlp(3'b010, 5'b01010, 9'd4, 16'h0003, 32'hA0);
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (cpl_ready_o === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_accept got=timeout exp=accepted"); end
        // Second TLP stays presented for the whole burst.
        drive_tlp(3'b010, 5'b01010, 9'd4, 16'h0005, 32'hB0);
        r_ready_i = pat[0];
        for (int c = 0; c < 40 && hs < 4; c++) begin
            @(negedge clk);
            n_checks++; if (r_valid_o !== 1'b1 || cpl_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_vld_rdy c=%0d got=%b%b exp=10", c, r_valid_o, cpl_ready_o); end
            n_checks++; if (r_data_o !== 32'hA0 + hs || r_last_o !== (hs == 3)) begin n_fail++; $display("FAIL stall_data c=%0d got=%h/%b exp=%h/%b", c, r_data_o, r_last_o, 32'hA0 + hs, hs == 3); end
            if (r_ready_i) hs++;
            else stalls++;
            @(posedge clk); #1;
            r_ready_i = pat[(c + 1) % 4];
        end
        n_checks++; if (hs != 4 || stalls != 4) begin n_fail++; $display("FAIL stall_beats got=%0d/%0d exp=4/4", hs, stalls); end
        exp_cpl++;
        @(negedge clk);
        n_checks++; if (r_valid_o !== 1'b0 || cpl_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_turnaround got=%b%b exp=01", r_valid_o, cpl_ready_o); end
        n_checks++; if (cpl_cnt_o !== 16'(exp_cpl)) begin n_fail++; $display("FAIL stall_cpl_cnt got=%0d exp=%0d", cpl_cnt_o, exp_cpl); end
        @(posedge clk); #1;
        cpl_valid_i = 1'b0;
        r_ready_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            n_checks++; if (r_valid_o !== 1'b1 || r_data_o !== 32'hB0 + b || r_id_o !== 4'd5) begin n_fail++; $display("FAIL stall_second b=%0d got=%b/%h/%h exp=1/%h/5", b, r_valid_o, r_data_o, r_id_o, 32'hB0 + b); end
            @(posedge clk); #1;
        end
        exp_cpl++;
        @(negedge clk);
        n_checks++; if (cpl_cnt_o !== 16'(exp_cpl)) begin n_fail++; $display("FAIL stall_cpl_cnt2 got=%0d exp=%0d", cpl_cnt_o, exp_cpl); end
        @(posedge clk); #1;
    endtask

    task automatic test_malformed();
        logic [2:0] fmts [3] = '{3'b000, 3'b010, 3'b010};
        logic [8:0] lens [3] = '{9'd4, 9'd0, 9'd33};
        bit ok;
        r_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept_tlp(fmts[i], 5'b01010, lens[i], 16'h0009, 32'h100, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL mal_accept i=%0d got=timeout exp=accepted", i); end
            @(negedge clk);
            n_checks++; if (r_valid_o !== 1'b1 || r_last_o !== 1'b1 || r_resp_o !== 2'b10) begin n_fail++; $display("FAIL mal_ctrl i=%0d got=%b%b%b exp=1110", i, r_valid_o, r_last_o, r_resp_o); end
            n_checks++; if (r_data_o !== 32'h0 || r_id_o !== 4'd9) begin n_fail++; $display("FAIL mal_data_id i=%0d got=%h/%h exp=0/9", i, r_data_o, r_id_o); end
            @(posedge clk); #1;
            exp_err++;
            @(negedge clk);
            n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL mal_single_beat i=%0d got=%b exp=0", i, r_valid_o); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (err_cnt_o !== 8'(exp_err) || cpl_cnt_o !== 16'(exp_cpl)) begin n_fail++; $display("FAIL mal_counters got=%0d/%0d exp=%0d/%0d", err_cnt_o, cpl_cnt_o, exp_err, exp_cpl); end
        @(posedge clk); #1;
    endtask

    task automatic test_len32();
        bit ok;
        int bad_data, bad_last;
        bad_data = 0;
        bad_last = 0;
        r_ready_i = 1'b1;
        accept_tlp(3'b010, 5'b01010, 9'd32, 16'h000C, 32'h0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL len32_accept got=timeout exp=accepted"); end
        for (int b = 0; b < 32; b++) begin
            @(negedge clk);
            n_checks++; if (r_valid_o !== 1'b1 || r_data_o !== 32'(b)) begin n_fail++; bad_data++; $display("FAIL len32_data b=%0d got=%b/%h exp=1/%h", b, r_valid_o, r_data_o, b); end
            n_checks++; if (r_last_o !== (b == 31)) begin n_fail++; bad_last++; $display("FAIL len32_last b=%0d got=%b exp=%b", b, r_last_o, b == 31); end
            @(posedge clk); #1;
        end
        exp_cpl++;
        @(negedge clk);
        n_checks++; if (r_valid_o !== 1'b0 || cpl_cnt_o !== 16'(exp_cpl)) begin n_fail++; $display("FAIL len32_end got=%b/%0d exp=0/%0d", r_valid_o, cpl_cnt_o, exp_cpl); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int stray;
        stray = 0;
        r_ready_i = 1'b1;
        accept_tlp(3'b010, 5'b01010, 9'd8, 16'h0002, 32'h200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_accept got=timeout exp=accepted"); end
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (r_data_o !== 32'h202 || cpl_ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_beat2 got=%h/%b exp=202/0", r_data_o, cpl_ready_o); end
        @(posedge clk); #1;
        exp_cpl = 0;
        exp_err = 0;
        repeat (2) begin
            @(negedge clk);
            if (r_valid_o !== 1'b0) stray++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cpl_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%b exp=1", cpl_ready_o); end
        n_checks++; if (cpl_cnt_o !== 16'h0 || err_cnt_o !== 8'h0) begin n_fail++; $display("FAIL rmid_counters got=%0d/%0d exp=0/0", cpl_cnt_o, err_cnt_o); end
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (r_valid_o !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL rmid_no_beats got=%0d exp=0", stray); end
        @(posedge clk); #1;
        accept_tlp(3'b010, 5'b01010, 9'd2, 16'h0007, 32'h300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_next_accept got=timeout exp=accepted"); end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            n_checks++; if (r_valid_o !== 1'b1 || r_data_o !== 32'h300 + b || r_last_o !== (b == 1)) begin n_fail++; $display("FAIL rmid_next_beat b=%0d got=%b/%h/%b exp=1/%h/%b", b, r_valid_o, r_data_o, r_last_o, 32'h300 + b, b == 1); end
            @(posedge clk); #1;
        end
        exp_cpl++;
        @(negedge clk);
        n_checks++; if (cpl_cnt_o !== 16'(exp_cpl)) begin n_fail++; $display("FAIL rmid_next_cnt got=%0d exp=%0d", cpl_cnt_o, exp_cpl); end
        @(posedge clk); #1;
    endtask

    task automatic test_err_saturate();
        bit ok;
        int timeouts;
        timeouts = 0;
        r_ready_i = 1'b1;
        for (int i = 0; i < 255; i++) begin
            accept_tlp(3'b000, 5'b00000, 9'd1, 16'h0001, 32'h0, ok);
            if (!ok) timeouts++;
            @(posedge clk); #1;
        end
        n_checks++; if (timeouts != 0) begin n_fail++; $display("FAIL sat_accepts got=%0d timeouts exp=0", timeouts); end
        @(negedge clk);
        n_checks++; if (err_cnt_o !== 8'd255) begin n_fail++; $display("FAIL sat_preload got=%0d exp=255", err_cnt_o); end
        @(posedge clk); #1;
        accept_tlp(3'b010, 5'b01010, 9'd40, 16'h0001, 32'h0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_extra_accept got=timeout exp=accepted"); end
        @(negedge clk);
        n_checks++; if (r_resp_o !== 2'b10 || r_valid_o !== 1'b1) begin n_fail++; $display("FAIL sat_extra_beat got=%b/%b exp=1/10", r_valid_o, r_resp_o); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (err_cnt_o !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", err_cnt_o); end
        n_checks++; if (cpl_cnt_o !== 16'(exp_cpl)) begin n_fail++; $display("FAIL sat_cpl_cnt got=%0d exp=%0d", cpl_cnt_o, exp_cpl); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        cpl_valid_i     = 1'b0;
        cpl_fmt_i       = '0;
        cpl_type_i      = '0;
        cpl_length_i    = '0;
        cpl_requestID_i = '0;
        cpl_data_i      = '0;
        r_ready_i       = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_malformed();
        test_len32();
        test_reset_mid();
        test_err_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
